cycle_sequencer: RTL and testbench

// - Generates the one-hot T-step (i_Cycle_Step) and M-cycle (i_Cycle_Count) buses consumed by every
//   *_Microcode decoder in the control unit (PUSH, POP, LD, ...).
// - Advances T-steps every enabled clock and M-cycles on the last T-step. Restarts at M1 when the active

---
 rtl/cycle_sequencer_pkg.sv | 36 +++
 rtl/cycle_sequencer_ring.sv | 22 ++
 rtl/cycle_sequencer.sv | 92 +++++++++
 tb/tb_cycle_sequencer.sv | 193 +++++++++++++++++++
 4 files changed

// File: rtl/cycle_sequencer_pkg.sv
// Shared control-unit definitions: sequencer widths, one-hot step/cycle constants,
// sequencer state encoding and the one-hot-to-binary helper reused by microcode debug logic.
package cycle_sequencer_pkg;

  localparam int STEP_W  = 4;
  localparam int COUNT_W = 8;

  localparam logic [STEP_W-1:0] T1 = 4'b0001;
  localparam logic [STEP_W-1:0] T2 = 4'b0010;
  localparam logic [STEP_W-1:0] T3 = 4'b0100;
  localparam logic [STEP_W-1:0] T4 = 4'b1000;

  localparam logic [COUNT_W-1:0] M1 = 8'h01;

  typedef enum logic {
    SEQ_RUN  = 1'b0,
    SEQ_HALT = 1'b1
  } seq_state_e;

  // OR-reduction encoder: exact for one-hot input, and an all-zero bus encodes to 0.
  function automatic logic [2:0] onehot_to_bin(input logic [COUNT_W-1:0] oh);
    logic [2:0] idx;
    idx = '0;
    for (int i = 0; i < COUNT_W; i++) begin
      if (oh[i]) idx = idx | 3'(i);
    end
    return idx;
  endfunction

  function automatic logic count_is_legal(input logic [COUNT_W-1:0] count,
                                          input seq_state_e state);
    if (state == SEQ_RUN) return $onehot(count);
    return (count == '0);
  endfunction

endpackage

// File: rtl/cycle_sequencer_ring.sv
// One-hot rotating ring used for the T-step bus; reloads to bit0 on request.
module onehot_ring #(
  parameter int W = 4
) (
  input  logic         i_Clk,
  input  logic         i_Rst_n,
  input  logic         i_En,
  input  logic         i_Load,
  output logic [W-1:0] o_Q
);

  // NOTE: sequential state is assigned with <= so every flop samples pre-edge values.
  always_ff @(posedge i_Clk or negedge i_Rst_n) begin
    if (!i_Rst_n) begin
      o_Q <= W'(1);
    end else if (i_En) begin
      if (i_Load) o_Q <= W'(1);
      else        o_Q <= {o_Q[W-2:0], o_Q[W-1]};
    end
  end

endmodule

// File: rtl/cycle_sequencer.sv
// T-step / M-cycle sequencer for the microcode decoders, with HALT/wake, bus-stall
// freezing, overrun detection and recovery from illegal encodings.
module cycle_sequencer
  import cycle_sequencer_pkg::*;
(
  input  logic               i_Clk,
  input  logic               i_Rst_n,
  input  logic               i_Stall,
  input  logic               i_IR_Fetch,
  input  logic               i_Halt,
  input  logic               i_Wake,
  output logic [STEP_W-1:0]  o_Cycle_Step,
  output logic [COUNT_W-1:0] o_Cycle_Count,
  output logic               o_M_Last,
  output logic               o_Instr_Start,
  output logic [2:0]         o_MCycle_Idx,
  output logic               o_Halted,
  output logic               o_Overrun
);

  logic [STEP_W-1:0]  step;
  logic [COUNT_W-1:0] count;
  seq_state_e         state;
  logic               instr_start;
  logic               overrun;

  logic adv;
  logic boundary;
  logic step_load;
  logic count_legal;

  assign adv         = ~i_Stall;
  assign boundary    = adv & step[STEP_W-1];
  assign step_load   = ~$onehot(step);
  assign count_legal = count_is_legal(count, state);

  onehot_ring #(.W(STEP_W)) u_step_ring (
    .i_Clk   (i_Clk),
    .i_Rst_n (i_Rst_n),
    .i_En    (adv),
    .i_Load  (step_load),
    .o_Q     (step)
  );

  // Start flag is a strict one-clock pulse: it drops even on a stalled clock so a
  // stall on T1 of M1 never stretches it into a second instruction start.
  always_ff @(posedge i_Clk or negedge i_Rst_n) begin
    if (!i_Rst_n) begin
      count       <= M1;
      state       <= SEQ_RUN;
      instr_start <= 1'b1;
      overrun     <= 1'b0;
    end else begin
      instr_start <= 1'b0;
      if (boundary) begin
        if (!count_legal) begin
          count       <= M1;
          state       <= SEQ_RUN;
          instr_start <= 1'b1;
        end else if (state == SEQ_HALT) begin
          if (i_Wake) begin
            state       <= SEQ_RUN;
            count       <= M1;
            instr_start <= 1'b1;
          end
        end else if (i_IR_Fetch) begin
          if (i_Halt && !i_Wake) begin
            state <= SEQ_HALT;
            count <= '0;
          end else begin
            count       <= M1;
            instr_start <= 1'b1;
          end
        end else if (count[COUNT_W-1]) begin
          count   <= M1;
          overrun <= 1'b1;
        end else begin
          count <= count << 1;
        end
      end
    end
  end

  assign o_Cycle_Step  = step;
  assign o_Cycle_Count = count;
  assign o_M_Last      = step[STEP_W-1] & (state != SEQ_HALT);
  assign o_Instr_Start = instr_start;
  assign o_MCycle_Idx  = onehot_to_bin(count);
  assign o_Halted      = (state == SEQ_HALT);
  assign o_Overrun     = overrun;

endmodule

// File: tb/tb_cycle_sequencer.sv
// Scoreboard bench for cycle_sequencer: a step/cycle-index reference model predicts
// every clock's outputs; a monitor pops and compares one entry per clock.
module tb_cycle_sequencer;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       i_Stall = 1'b0, i_IR_Fetch = 1'b0, i_Halt = 1'b0, i_Wake = 1'b0;
  logic [3:0] o_Cycle_Step;
  logic [7:0] o_Cycle_Count;
  logic       o_M_Last, o_Instr_Start, o_Halted, o_Overrun;
  logic [2:0] o_MCycle_Idx;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  cycle_sequencer dut (
    .i_Clk         (clk),
    .i_Rst_n       (rst_n),
    .i_Stall       (i_Stall),
    .i_IR_Fetch    (i_IR_Fetch),
    .i_Halt        (i_Halt),
    .i_Wake        (i_Wake),
    .o_Cycle_Step  (o_Cycle_Step),
    .o_Cycle_Count (o_Cycle_Count),
    .o_M_Last      (o_M_Last),
    .o_Instr_Start (o_Instr_Start),
    .o_MCycle_Idx  (o_MCycle_Idx),
    .o_Halted      (o_Halted),
    .o_Overrun     (o_Overrun)
  );

  typedef struct {
    logic [3:0] step;
    logic [7:0] count;
    logic       m_last;
    logic       start;
    logic [2:0] idx;
    logic       halted;
    logic       overrun;
  } exp_t;

  exp_t exp_q[$];

  // Reference model: T-step number 0..3, M-cycle number 0..7, halted flag.
  int mt, mm;
  bit mh, mstart, mov;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, req, $time);
    end
  endtask

  function automatic void model_reset();
    mt = 0; mm = 0; mh = 0; mstart = 1; mov = 0;
  endfunction

  function automatic void model_step(bit st, bit fe, bit ha, bit wk);
    mstart = 0;
    if (st) return;
    if (mt == 3) begin
      if (mh) begin
        if (wk) begin mh = 0; mm = 0; mstart = 1; end
      end else if (fe) begin
        if (ha && !wk) mh = 1;
        else begin mm = 0; mstart = 1; end
      end else if (mm == 7) begin
        mm = 0; mov = 1;
      end else begin
        mm = mm + 1;
      end
    end
    mt = (mt + 1) % 4;
  endfunction

  function automatic exp_t model_out();
    exp_t e;
    e.step    = 4'(1 << mt);
    e.count   = mh ? 8'h00 : 8'(1 << mm);
    e.m_last  = (mt == 3) && !mh;
    e.start   = mstart;
    e.idx     = mh ? 3'd0 : 3'(mm);
    e.halted  = mh;
    e.overrun = mov;
    return e;
  endfunction

  // One clock of stimulus: inputs change on the falling edge, model predicts the
  // state after the following rising edge.
  task automatic cyc(input bit rst, input bit st, input bit fe, input bit ha, input bit wk);
    @(negedge clk);
    i_Stall = st; i_IR_Fetch = fe; i_Halt = ha; i_Wake = wk;
    rst_n = !rst;
    if (rst) model_reset();
    else     model_step(st, fe, ha, wk);
    exp_q.push_back(model_out());
  endtask

  exp_t got;
  always begin
    @(posedge clk);
    #1;
    if (exp_q.size() > 0) begin
      got = exp_q.pop_front();
      check("step",    32'(o_Cycle_Step),  32'(got.step));
      check("count",   32'(o_Cycle_Count), 32'(got.count));
      check("m_last",  32'(o_M_Last),      32'(got.m_last));
      check("start",   32'(o_Instr_Start), 32'(got.start));
      check("idx",     32'(o_MCycle_Idx),  32'(got.idx));
      check("halted",  32'(o_Halted),      32'(got.halted));
      check("overrun", 32'(o_Overrun),     32'(got.overrun));
    end
  end

  initial begin
    bit found;

    // Reset, then IR_Fetch tied high: single-M-cycle instructions.
    cyc(1, 0, 0, 0, 0);
    #1;
    check("rst_step",    32'(o_Cycle_Step),  32'h1);
    check("rst_count",   32'(o_Cycle_Count), 32'h01);
    check("rst_start",   32'(o_Instr_Start), 32'h1);
    check("rst_overrun", 32'(o_Overrun),     32'h0);
    cyc(1, 0, 0, 0, 0);
    repeat (12) cyc(0, 0, 1, 0, 0);

    // Four-M-cycle PUSH: fetch raised only during M4.
    repeat (20) cyc(0, 0, (mm == 3), 0, 0);

    // Stall three clocks at T3 of M2, then finish the instruction.
    found = 0;
    for (int i = 0; i < 40 && !found; i++) begin
      if (mt == 2 && mm == 1 && !mh) found = 1;
      else cyc(0, 0, (mm == 3), 0, 0);
    end
    check("reach_stall_point", 32'(found), 32'h1);
    repeat (3) cyc(0, 1, 1, 1, 1);
    repeat (20) cyc(0, 0, (mm == 3), 0, 0);

    // HALT requested with IR_Fetch at M1.
    found = 0;
    for (int i = 0; i < 20 && !found; i++) begin
      cyc(0, 0, 1, 1, 0);
      if (mh) found = 1;
    end
    check("enter_halt", 32'(found), 32'h1);
    repeat (7) cyc(0, 0, 32'($urandom_range(0, 1)) != 0, 1, 0);
    found = 0;
    for (int i = 0; i < 8 && !found; i++) begin
      if (mt == 1) found = 1;
      else cyc(0, 0, 0, 0, 0);
    end
    check("reach_wake_point", 32'(found), 32'h1);
    found = 0;
    for (int i = 0; i < 8 && !found; i++) begin
      cyc(0, 0, 0, 0, 1);
      if (!mh) found = 1;
    end
    check("leave_halt", 32'(found), 32'h1);
    repeat (4) cyc(0, 0, 0, 0, 0);

    // IR_Fetch never raised: overrun after M8/T4, sticky until reset.
    repeat (40) cyc(0, 0, 0, 0, 0);
    repeat (6) cyc(0, 0, 1, 0, 0);
    cyc(1, 0, 0, 0, 0);
    #1;
    check("mid_rst_overrun", 32'(o_Overrun),    32'h0);
    check("mid_rst_step",    32'(o_Cycle_Step), 32'h1);
    cyc(0, 0, 1, 0, 0);

    // Randomized traffic with occasional asynchronous reset.
    for (int i = 0; i < 3000; i++) begin
      cyc(($urandom_range(0, 199) == 0),
          ($urandom_range(0, 4) == 0),
          ($urandom_range(0, 3) == 0),
          ($urandom_range(0, 5) == 0),
          ($urandom_range(0, 4) == 0));
    end
    cyc(0, 0, 0, 0, 0);

    @(posedge clk);
    #2;
    check("queue_drained", 32'(exp_q.size()), 32'h0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
